data_memory_port: RTL and testbench

Parametrised successor to the single-cycle data memory: a word-organised data RAM behind a valid/ready request/response port.
- Supports RV32I sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte lanes and sign/zero extension.
- Configurable access latency and misalignment detection.
- Sits between the CPU's ALU address/rs2 path and the register write-back mux; lets a future multi-cycle core stall on memory.

---
 rtl/mem_access_pkg.sv | 57 +++++
 rtl/load_extract.sv | 29 ++
 rtl/data_memory_port.sv | 182 ++++++++++++++++++
 tb/tb_data_memory_port.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared RV32I load/store width encodings, FSM states and access helpers
// for the data memory port and its load-extraction unit.
package mem_access_pkg;

  typedef enum logic [2:0] {
    MW_BYTE   = 3'b000,
    MW_HALF   = 3'b001,
    MW_WORD   = 3'b010,
    MW_BYTE_U = 3'b100,
    MW_HALF_U = 3'b101
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic w_mis;
    case (funct3)
      MW_HALF, MW_HALF_U: w_mis = offset[0];
      MW_WORD:            w_mis = (offset != 2'b00);
      default:            w_mis = 1'b0;
    endcase
    return w_mis;
  endfunction

  // Unsigned widths only exist for loads.
  function automatic logic is_illegal(input logic [2:0] funct3, input logic write);
    logic w_ill;
    case (funct3)
      MW_BYTE, MW_HALF, MW_WORD: w_ill = 1'b0;
      MW_BYTE_U, MW_HALF_U:      w_ill = write;
      default:                   w_ill = 1'b1;
    endcase
    return w_ill;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                              input logic [2:0] funct3, input logic [1:0] offset);
    logic [31:0] w_word;
    w_word = old_word;
    case (funct3)
      MW_BYTE: w_word[{offset, 3'b000} +: 8]     = wdata[7:0];
      MW_HALF: w_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      MW_WORD: w_word = wdata;
      default: w_word = old_word;
    endcase
    return w_word;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational RV32I load lane select and sign/zero extension.
module load_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_data = 32'h0000_0000;
    case (i_funct3)
      MW_BYTE:   o_data = {{24{w_byte[7]}}, w_byte};
      MW_HALF:   o_data = {{16{w_half[15]}}, w_half};
      MW_WORD:   o_data = i_word;
      MW_BYTE_U: o_data = {24'h00_0000, w_byte};
      MW_HALF_U: o_data = {16'h0000, w_half};
      default:   o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_memory_port.sv
// Word-organised data RAM behind a valid/ready request/response port with
// configurable latency. Optional counters enabled by DATA_MEMORY_STATS_EN.
module data_memory_port
  import mem_access_pkg::*;
#(
  parameter  int DEPTH_WORDS = 32,
  parameter  int LATENCY     = 1,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [2:0]                   req_funct3,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_rdata,
  output logic                         resp_error,
`ifdef DATA_MEMORY_STATS_EN
  output logic [15:0]                  stat_loads,
  output logic [15:0]                  stat_stores,
  output logic [15:0]                  stat_errors,
`endif
  input  logic [DEPTH_WORDS-1:0][31:0] initial_values,
  output logic [DEPTH_WORDS-1:0][31:0] memory_check
);

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  mem_state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_count, w_count_nxt;
  logic                        w_accept, w_access;
  logic                        r_write;
  logic [2:0]                  r_funct3;
  logic [IDX_W+1:0]            r_addr;
  logic [31:0]                 r_wdata;
  logic [DEPTH_WORDS-1:0][31:0] r_mem;
  logic [31:0]                 r_rdata;
  logic                        r_error;

  logic                        w_acc_write;
  logic [2:0]                  w_acc_funct3;
  logic [IDX_W+1:0]            w_acc_addr;
  logic [31:0]                 w_acc_wdata;
  logic [IDX_W-1:0]            w_idx;
  logic [1:0]                  w_offset;
  logic [31:0]                 w_old_word, w_load_data;
  logic                        w_err;
  logic                        w_unused_addr;

  assign w_unused_addr = ^req_addr[31:IDX_W+2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_count_nxt = CNT_W'(LATENCY - 2);
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (r_count == '0) begin
          w_state_nxt = RESP;
          w_access    = 1'b1;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Zero-latency-to-latch path: in IDLE the access uses the live request.
  assign w_acc_write  = (r_state == IDLE) ? req_write            : r_write;
  assign w_acc_funct3 = (r_state == IDLE) ? req_funct3           : r_funct3;
  assign w_acc_addr   = (r_state == IDLE) ? req_addr[IDX_W+1:0]  : r_addr;
  assign w_acc_wdata  = (r_state == IDLE) ? req_wdata            : r_wdata;
  assign w_idx        = w_acc_addr[IDX_W+1:2];
  assign w_offset     = w_acc_addr[1:0];
  assign w_old_word   = r_mem[w_idx];
  assign w_err        = is_illegal(w_acc_funct3, w_acc_write) | is_misaligned(w_acc_funct3, w_offset);

  load_extract u_load_extract (
    .i_word   (w_old_word),
    .i_offset (w_offset),
    .i_funct3 (w_acc_funct3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0000_0000;
      r_rdata  <= 32'h0000_0000;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[IDX_W+1:0];
        r_wdata  <= req_wdata;
      end
      if (w_access) begin
        r_error <= w_err;
        r_rdata <= (w_err || w_acc_write) ? 32'h0000_0000 : w_load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem <= initial_values;
    end else if (w_access && w_acc_write && !w_err) begin
      r_mem[w_idx] <= store_merge(w_old_word, w_acc_wdata, w_acc_funct3, w_offset);
    end
  end

`ifdef DATA_MEMORY_STATS_EN
  logic [15:0] r_stat_loads, r_stat_stores, r_stat_errors;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_loads  <= 16'h0000;
      r_stat_stores <= 16'h0000;
      r_stat_errors <= 16'h0000;
    end else if (w_access) begin
      if (w_err) begin
        r_stat_errors <= sat_inc16(r_stat_errors);
      end else if (w_acc_write) begin
        r_stat_stores <= sat_inc16(r_stat_stores);
      end else begin
        r_stat_loads  <= sat_inc16(r_stat_loads);
      end
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errors = r_stat_errors;
`endif

  assign req_ready    = (r_state == IDLE);
  assign resp_valid   = (r_state == RESP);
  assign resp_rdata   = r_rdata;
  assign resp_error   = r_error;
  assign memory_check = r_mem;

endmodule

// File: tb/tb_data_memory_port.sv
// Directed bench for data_memory_port: one LATENCY=1 instance for load/store
// semantics and one LATENCY=3 instance for timing, backpressure and reset.
module tb_data_memory_port;

  logic clk, reset;
  logic [31:0][31:0] init;
  int n_checks = 0;
  int n_errors = 0;

  logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_error1;
  logic [2:0]  req_funct3_1;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1;
  logic [31:0][31:0] mem1;
  logic        req_valid3, req_ready3, req_write3, resp_valid3, resp_ready3, resp_error3;
  logic [2:0]  req_funct3_3;
  logic [31:0] req_addr3, req_wdata3, resp_rdata3;
  logic [31:0][31:0] mem3;
  logic [31:0] held;
`ifdef DATA_MEMORY_STATS_EN
  logic [15:0] sl1, ss1, se1, sl3, ss3, se3;
`endif

  data_memory_port #(.DEPTH_WORDS(32), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_funct3(req_funct3_1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_error(resp_error1),
`ifdef DATA_MEMORY_STATS_EN
    .stat_loads(sl1), .stat_stores(ss1), .stat_errors(se1),
`endif
    .initial_values(init), .memory_check(mem1)
  );

  data_memory_port #(.DEPTH_WORDS(32), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write3), .req_funct3(req_funct3_3), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_rdata(resp_rdata3), .resp_error(resp_error3),
`ifdef DATA_MEMORY_STATS_EN
    .stat_loads(sl3), .stat_stores(ss3), .stat_errors(se3),
`endif
    .initial_values(init), .memory_check(mem3)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; leaves the LATENCY=1 port idle, same phase.
  task automatic txn1(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    req_valid1 = 1'b1; req_write1 = wr; req_funct3_1 = f3;
    req_addr1 = addr; req_wdata1 = wd; resp_ready1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    check_value({tag, "_valid"}, {31'd0, resp_valid1}, 32'd1);
    check_value({tag, "_rdata"}, resp_rdata1, exp_rd);
    check_value({tag, "_error"}, {31'd0, resp_error1}, {31'd0, exp_err});
    @(posedge clk); #1;
    check_value({tag, "_retire"}, {31'd0, resp_valid1}, 32'd0);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0;
    for (int i = 0; i < 32; i++) init[i] = {8'hA0, 8'(i), 16'h5A5A};
    init[0] = 32'h0BAD_F00D;
    init[1] = 32'h8000_F0A5;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_funct3_1 = 3'b000; req_addr1 = 32'd0;
    req_wdata1 = 32'd0; resp_ready1 = 1'b0;
    req_valid3 = 1'b0; req_write3 = 1'b0; req_funct3_3 = 3'b000; req_addr3 = 32'd0;
    req_wdata3 = 32'd0; resp_ready3 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_value("rst_mem1", mem1[1], 32'h8000_F0A5);
    check_value("rst_resp_valid", {31'd0, resp_valid1}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_value("rel_req_ready", {31'd0, req_ready1}, 32'd1);
    check_value("rel_rdata", resp_rdata1, 32'd0);
    check_value("rel_error", {31'd0, resp_error1}, 32'd0);

    txn1("lb",  1'b0, 3'b000, 32'd4, 32'd0, 32'hFFFF_FFA5, 1'b0);
    txn1("lbu", 1'b0, 3'b100, 32'd4, 32'd0, 32'h0000_00A5, 1'b0);
    txn1("lh",  1'b0, 3'b001, 32'd6, 32'd0, 32'hFFFF_8000, 1'b0);
    txn1("lhu", 1'b0, 3'b101, 32'd6, 32'd0, 32'h0000_8000, 1'b0);
    txn1("lw",  1'b0, 3'b010, 32'd4, 32'd0, 32'h8000_F0A5, 1'b0);

    txn1("sb", 1'b1, 3'b000, 32'd5, 32'hDEAD_BE12, 32'd0, 1'b0);
    check_value("sb_mem", mem1[1], 32'h8000_12A5);
    txn1("sh", 1'b1, 3'b001, 32'd6, 32'h0000_7777, 32'd0, 1'b0);
    check_value("sh_mem", mem1[1], 32'h7777_12A5);
    txn1("sw", 1'b1, 3'b010, 32'd0, 32'h0123_4567, 32'd0, 1'b0);
    check_value("sw_mem", mem1[0], 32'h0123_4567);

    txn1("lw_mis", 1'b0, 3'b010, 32'd6, 32'd0, 32'd0, 1'b1);
    txn1("sh_mis", 1'b1, 3'b001, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b1);
    check_value("sh_mis_mem", mem1[0], 32'h0123_4567);
    txn1("f3_011", 1'b0, 3'b011, 32'd0, 32'd0, 32'd0, 1'b1);
    txn1("wrap", 1'b0, 3'b010, 32'h0000_0080, 32'd0, 32'h0123_4567, 1'b0);

`ifdef DATA_MEMORY_STATS_EN
    check_value("stat_loads", {16'd0, sl1}, 32'd6);
    check_value("stat_stores", {16'd0, ss1}, 32'd3);
    check_value("stat_errors", {16'd0, se1}, 32'd3);
`endif

    // LATENCY=3: accept at edge T, response visible after edge T+2.
    req_valid3 = 1'b1; req_write3 = 1'b0; req_funct3_3 = 3'b010; req_addr3 = 32'd4;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    check_value("l3_t0_valid", {31'd0, resp_valid3}, 32'd0);
    check_value("l3_t0_ready", {31'd0, req_ready3}, 32'd0);
    @(posedge clk); #1;
    check_value("l3_t1_valid", {31'd0, resp_valid3}, 32'd0);
    @(posedge clk); #1;
    check_value("l3_t2_valid", {31'd0, resp_valid3}, 32'd1);
    check_value("l3_rdata", resp_rdata3, 32'h8000_F0A5);
    held = resp_rdata3;
    req_valid3 = 1'b1; req_write3 = 1'b1; req_funct3_3 = 3'b010; req_wdata3 = 32'd0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_value("bp_valid", {31'd0, resp_valid3}, 32'd1);
      check_value("bp_rdata", resp_rdata3, held);
      check_value("bp_ready", {31'd0, req_ready3}, 32'd0);
    end
    req_valid3 = 1'b0; resp_ready3 = 1'b1;
    @(posedge clk); #1;
    resp_ready3 = 1'b0;
    check_value("bp_retire", {31'd0, resp_valid3}, 32'd0);
    check_value("bp_ignored", mem3[1], 32'h8000_F0A5);

    // Reset during WAIT of a store discards it.
    req_valid3 = 1'b1; req_write3 = 1'b1; req_funct3_3 = 3'b010;
    req_addr3 = 32'd8; req_wdata3 = 32'hCAFE_BABE; resp_ready3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    check_value("wait_ready", {31'd0, req_ready3}, 32'd0);
    reset = 1'b0;
    #1;
    check_value("mid_rst_valid", {31'd0, resp_valid3}, 32'd0);
    check_value("mid_rst_rdata", resp_rdata3, 32'd0);
    check_value("mid_rst_mem", mem3[2], init[2]);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_value("post_rst_mem", mem3[2], init[2]);
    check_value("post_rst_valid", {31'd0, resp_valid3}, 32'd0);
    check_value("post_rst_ready", {31'd0, req_ready3}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
